// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions
// and the active-high hex glyph patterns, bit order {g,f,e,d,c,b,a}.
package seven_segment_scanner_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] MA = 7'(1 << SEG_A);
    localparam logic [6:0] MB = 7'(1 << SEG_B);
    localparam logic [6:0] MC = 7'(1 << SEG_C);
    localparam logic [6:0] MD = 7'(1 << SEG_D);
    localparam logic [6:0] ME = 7'(1 << SEG_E);
    localparam logic [6:0] MF = 7'(1 << SEG_F);
    localparam logic [6:0] MG = 7'(1 << SEG_G);

    localparam logic [6:0] SEG_0 = MA | MB | MC | MD | ME | MF;
    localparam logic [6:0] SEG_1 = MB | MC;
    localparam logic [6:0] SEG_2 = MA | MB | MD | ME | MG;
    localparam logic [6:0] SEG_3 = MA | MB | MC | MD | MG;
    localparam logic [6:0] SEG_4 = MB | MC | MF | MG;
    localparam logic [6:0] SEG_5 = MA | MC | MD | MF | MG;
    localparam logic [6:0] SEG_6 = MA | MC | MD | ME | MF | MG;
    localparam logic [6:0] SEG_7 = MA | MB | MC;
    localparam logic [6:0] SEG_8 = MA | MB | MC | MD | ME | MF | MG;
    localparam logic [6:0] SEG_9 = MA | MB | MC | MD | MF | MG;
    localparam logic [6:0] SEG_HA = MA | MB | MC | ME | MF | MG;
    localparam logic [6:0] SEG_HB = MC | MD | ME | MF | MG;
    localparam logic [6:0] SEG_HC = MA | MD | ME | MF;
    localparam logic [6:0] SEG_HD = MB | MC | MD | ME | MG;
    localparam logic [6:0] SEG_HE = MA | MD | ME | MF | MG;
    localparam logic [6:0] SEG_HF = MA | ME | MF | MG;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
// Output polarity is applied by the scanner's output registers.
module hex_segment_decoder
    import seven_segment_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_HA;
            4'hB: seg = SEG_HB;
            4'hC: seg = SEG_HC;
            4'hD: seg = SEG_HD;
            4'hE: seg = SEG_HE;
            4'hF: seg = SEG_HF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with per-frame snapshot,
// leading-zero blanking, PWM brightness and a dark dead step per slot.
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE_LOG2  = 10,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_enable,
    input  logic                  i_lzb,
    input  logic [BRIGHT_W-1:0]   i_bright,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_select,
    output logic                  o_frame
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP_SH = PRESCALE_LOG2 - BRIGHT_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    // XOR masks: outputs idle at these values, lit bits flip away from them
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic DP_OFF = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};

    logic [PRESCALE_LOG2-1:0] cnt;
    logic [IDX_W-1:0]         idx;
    logic [4*DIGITS-1:0]      sh_data;
    logic [DIGITS-1:0]        sh_dp;
    logic [DIGITS-1:0]        sh_en;
    logic                     sh_lzb;
    logic [BRIGHT_W-1:0]      sh_bright;

    logic                cnt_wrap;
    logic                frame_wrap;
    logic [BRIGHT_W-1:0] step;
    logic [3:0]          nibble;
    logic [6:0]          pattern;
    logic [DIGITS-1:0]   blank;
    logic                nz;
    logic                lit;
    logic [6:0]          seg_on;
    logic [DIGITS-1:0]   sel_on;
    logic                dp_on;

    assign cnt_wrap   = &cnt;
    assign frame_wrap = cnt_wrap && (idx == LAST);
    assign step       = cnt[PRESCALE_LOG2-1:STEP_SH];
    assign nibble     = sh_data[idx*4 +: 4];

    // Walk from the top digit down; a digit is blankable while nothing above is non-zero
    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz       = nz | (|sh_data[4*k +: 4]);
            blank[k] = sh_lzb && (k != 0) && !nz;
        end
    end

    hex_segment_decoder u_dec (
        .nibble (nibble),
        .seg    (pattern)
    );

    assign lit = (step != '0) && (step <= sh_bright)
               && sh_en[idx] && !blank[idx];

    assign seg_on = lit ? pattern : 7'd0;
    assign sel_on = lit ? (DIGITS'(1) << idx) : '0;
    assign dp_on  = lit && sh_dp[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            sh_lzb    <= 1'b0;
            sh_bright <= '0;
            o_seg     <= SEG_OFF;
            o_dp      <= DP_OFF;
            o_select  <= SEL_OFF;
            o_frame   <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            o_frame <= frame_wrap;
            if (cnt_wrap) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            if (frame_wrap) begin
                sh_data   <= i_data;
                sh_dp     <= i_dp;
                sh_en     <= i_enable;
                sh_lzb    <= i_lzb;
                sh_bright <= i_bright;
            end
            o_seg    <= seg_on ^ SEG_OFF;
            o_dp     <= dp_on ^ DP_OFF;
            o_select <= sel_on ^ SEL_OFF;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: per-cycle scoreboard against
// a reference model plus per-frame checks of lit time and glyphs.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_data = '0;
    logic [3:0]  i_dp = '0;
    logic [3:0]  i_enable = '0;
    logic        i_lzb = 1'b0;
    logic [1:0]  i_bright = '0;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_select;
    logic        o_frame;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .DIGITS         (4),
        .PRESCALE_LOG2  (4),
        .BRIGHT_W       (2),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .i_dp     (i_dp),
        .i_enable (i_enable),
        .i_lzb    (i_lzb),
        .i_bright (i_bright),
        .o_seg    (o_seg),
        .o_dp     (o_dp),
        .o_select (o_select),
        .o_frame  (o_frame)
    );

    // Active-high glyphs {g,f,e,d,c,b,a}, written out from the letter lists
    localparam logic [6:0] PAT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       frame;
    } exp_t;

    exp_t q[$];

    int passes = 0;
    int total  = 0;

    int          m_cnt, m_idx;
    logic [15:0] s_data;
    logic [3:0]  s_dp, s_en;
    logic        s_lzb;
    logic [1:0]  s_bright;

    int         ftick;
    int         lit_cnt [4];
    int         first_lit [4];
    logic [6:0] last_seg [4];
    logic       last_dp [4];
    int         frame_cnt, frame_at;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) passes++;
        else $error("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int step;
        logic [3:0] nib;
        logic [3:0] one;
        logic blanked, lit;
        step = m_cnt / 4;
        nib = 4'((s_data >> (4 * m_idx)) & 16'hF);
        blanked = s_lzb && (m_idx > 0) && ((s_data >> (4 * m_idx)) == 16'h0);
        lit = (step >= 1) && (step <= int'(s_bright))
            && s_en[m_idx] && !blanked;
        one = 4'(1 << m_idx);
        e.sel = lit ? ~one : 4'hF;
        e.seg = lit ? ~PAT[nib] : 7'h7F;
        e.dp = lit ? ~s_dp[m_idx] : 1'b1;
        e.frame = (m_cnt == 15) && (m_idx == 3);
        return e;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0;
        s_data = '0; s_dp = '0; s_en = '0; s_lzb = 1'b0; s_bright = '0;
        q.delete();
    endtask

    task automatic clr_stats();
        ftick = 0; frame_cnt = 0; frame_at = 0;
        for (int d = 0; d < 4; d++) begin
            lit_cnt[d] = 0; first_lit[d] = 0;
            last_seg[d] = 7'h7F; last_dp[d] = 1'b1;
        end
    endtask

    task automatic tick();
        exp_t e, w;
        logic [3:0] one;
        q.push_back(model_out());
        @(posedge clk);
        if (m_cnt == 15 && m_idx == 3) begin
            s_data = i_data; s_dp = i_dp; s_en = i_enable;
            s_lzb = i_lzb; s_bright = i_bright;
        end
        m_cnt = (m_cnt + 1) % 16;
        if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
        #1;
        ftick++;
        w = q.pop_front();
        e = '{seg: o_seg, dp: o_dp, sel: o_select, frame: o_frame};
        chk("cycle", 32'(e), 32'(w));
        for (int d = 0; d < 4; d++) begin
            one = 4'(1 << d);
            if (o_select == ~one) begin
                lit_cnt[d]++;
                last_seg[d] = o_seg;
                last_dp[d] = o_dp;
                if (first_lit[d] == 0) first_lit[d] = ftick;
            end
        end
        if (o_frame) begin
            frame_cnt++;
            frame_at = ftick;
        end
    endtask

    task automatic run(input int n);
        clr_stats();
        repeat (n) tick();
    endtask

    task automatic chk_lit(input string tag, input int a, input int b,
                           input int c, input int d);
        chk({tag, "_d0"}, 32'(lit_cnt[0]), 32'(a));
        chk({tag, "_d1"}, 32'(lit_cnt[1]), 32'(b));
        chk({tag, "_d2"}, 32'(lit_cnt[2]), 32'(c));
        chk({tag, "_d3"}, 32'(lit_cnt[3]), 32'(d));
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_sel", 32'(o_select), 32'h0000000F);
        chk("rst_seg", 32'(o_seg), 32'h0000007F);
        chk("rst_dp", 32'(o_dp), 32'h1);
        chk("rst_frame", 32'(o_frame), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        i_data = 16'h1234; i_dp = 4'b0001; i_enable = 4'b1111;
        i_bright = 2'd3; i_lzb = 1'b0;
        run(64);
        chk_lit("f1_dark", 0, 0, 0, 0);
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f1_frame_at", 32'(frame_at), 32'd64);

        i_bright = 2'd1;
        run(64);
        chk_lit("f2_b3", 12, 12, 12, 12);
        chk("f2_first0", 32'(first_lit[0]), 32'd5);
        chk("f2_seg0", 32'(last_seg[0]), 32'b0011001);
        chk("f2_dp0", 32'(last_dp[0]), 32'h0);
        chk("f2_seg3", 32'(last_seg[3]), 32'b1111001);
        chk("f2_dp3", 32'(last_dp[3]), 32'h1);

        i_bright = 2'd0;
        run(64);
        chk_lit("f3_b1", 4, 4, 4, 4);
        chk("f3_first1", 32'(first_lit[1]), 32'd21);

        i_bright = 2'd3;
        run(64);
        chk_lit("f4_b0", 0, 0, 0, 0);

        run(32);
        i_data = 16'hABCD;
        repeat (32) tick();
        chk("f5_seg0", 32'(last_seg[0]), 32'b0011001);
        chk("f5_seg1", 32'(last_seg[1]), 32'b0110000);

        i_lzb = 1'b1; i_data = 16'h0050;
        run(64);
        chk("f6_seg0", 32'(last_seg[0]), 32'b0100001);
        chk("f6_seg3", 32'(last_seg[3]), 32'b0001000);

        i_data = 16'h0000;
        run(64);
        chk_lit("f7_lzb", 12, 12, 0, 0);
        chk("f7_seg1", 32'(last_seg[1]), 32'b0010010);
        chk("f7_seg0", 32'(last_seg[0]), 32'b1000000);

        i_enable = 4'b1101;
        run(64);
        chk_lit("f8_zero", 12, 0, 0, 0);
        chk("f8_seg0", 32'(last_seg[0]), 32'b1000000);

        i_data = 16'h0050;
        run(64);
        chk_lit("f9_en", 12, 0, 0, 0);
        run(64);
        chk_lit("f10_en", 12, 0, 0, 0);
        chk("f10_frame_at", 32'(frame_at), 32'd64);

        run(8);
        chk("pre_rst_sel", 32'(o_select), 32'b1110);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sel", 32'(o_select), 32'h0000000F);
        chk("mid_rst_seg", 32'(o_seg), 32'h0000007F);
        chk("mid_rst_dp", 32'(o_dp), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        run(64);
        chk_lit("post_rst_dark", 0, 0, 0, 0);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("post_rst_frame_at", 32'(frame_at), 32'd64);
        run(64);
        chk_lit("post_rst_lit", 12, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
